// File: rtl/riscv_fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
//   fetch_entry_t : {pc, instr} pair held in the prefetch buffer (default widths)
//   PC_STEP       : byte increment between sequential fetches
//   align_pc()    : clears the two low address bits of a fetch target
package riscv_fetch_pkg;

  localparam int PC_W_DEF   = 9;
  localparam int INST_W_DEF = 32;
  localparam int PC_STEP    = 4;
  // Widest PC the align helper handles; callers cast in and out.
  localparam int ALIGN_W    = 64;

  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [INST_W_DEF-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ALIGN_W-1:0] align_pc(input logic [ALIGN_W-1:0] pc);
    return {pc[ALIGN_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of {pc, instr} entries.
//   clk, reset : clock, asynchronous active-high reset
//   flush      : synchronous clear of all entries (wins over push)
//   push, din  : write din at the tail
//   pop        : drop the head entry (ignored when empty)
//   dout       : head entry (stale contents when empty)
//   count      : number of occupied entries
// The producer never pushes into a full buffer without popping the same cycle.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  entry_t                     din,
  input  logic                       pop,
  output entry_t                     dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic               pop_ok;

  // Full/empty come from count; pointers wrap naturally (DEPTH is a power of two).
  assign pop_ok = pop && (count != '0);
  assign dout   = mem[head];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= din;
        tail      <= tail + PTR_W'(1);
      end
      if (pop_ok) head <= head + PTR_W'(1);
      case ({push, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, one-deep in-flight tracking and a
// DEPTH-entry prefetch buffer between instruction memory and decode.
//   imem_req/imem_addr/imem_rdata : memory read port, data returns one cycle later
//   redirect_valid/redirect_pc    : taken branch/jump; flush and refetch
//   deq_valid/deq_ready/deq_pc/deq_instr : head entry to decode
//   count                         : occupied buffer entries
//   fetch_pc                      : current fetch PC (trace)
// Handshake: an entry moves to decode on a clock edge where deq_valid && deq_ready;
// deq_valid never depends on deq_ready, and deq_pc/deq_instr are meaningful only
// while deq_valid is high.
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter int              INST_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [INST_W-1:0]          imem_rdata,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [PC_W-1:0]            deq_pc,
  output logic [INST_W-1:0]          deq_instr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [PC_W-1:0]            fetch_pc
);

  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] instr;
  } entry_t;

  logic            inflight;
  logic [PC_W-1:0] inflight_pc;
  logic [CNT_W:0]  occupancy;
  logic            push;
  logic            pop;
  entry_t          push_entry;
  entry_t          head_entry;

  // Credit: buffered plus outstanding must stay below DEPTH, so the response to
  // any request always has a slot even if decode stalls.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign imem_req  = !redirect_valid && (occupancy < (CNT_W+1)'(DEPTH));
  assign imem_addr = fetch_pc;

  // A response landing in a redirect cycle belongs to the old path.
  assign push             = inflight && !redirect_valid;
  assign push_entry.pc    = inflight_pc;
  assign push_entry.instr = imem_rdata;

  assign deq_valid = (count != '0);
  assign pop       = deq_valid && deq_ready;
  assign deq_pc    = head_entry.pc;
  assign deq_instr = head_entry.instr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= PC_W'(align_pc(ALIGN_W'(redirect_pc)));
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + PC_W'(PC_STEP);
      end
    end
  end

  // A head handshake in a redirect cycle still completes: decode took it, and
  // the flush discards everything behind it.
  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head_entry),
    .count (count)
  );

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end for the pipelined RISC-V core: PC generator plus a DEPTH-entry prefetch buffer of {pc, instr} pairs.
- Sits between instruction memory and the IF/ID boundary and decouples fetch from decode stalls.
- Applies branch/jump redirects by flushing buffered and in-flight instructions.
- Generalises the fixed 9-bit PC of the current core to PC_W, and adds buffering depth and redirect handling.

Parameters:
PC_W, 9, program-counter width in bits (byte address)
INST_W, 32, instruction width in bits
DEPTH, 4, buffer entries; power of two, at least 2
RESET_PC, 0, PC value loaded on reset; low 2 bits must be 0

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  instruction-memory read request this cycle
imem_addr  out  PC_W  read address (current fetch PC)
imem_rdata  in  INST_W  read data, valid exactly one cycle after a request
redirect_valid  in  1  branch/jump taken; flush and restart fetch
redirect_pc  in  PC_W  new fetch target; bits [1:0] ignored and treated as 0
deq_valid  out  1  head entry available
deq_ready  in  1  decode accepts head entry
deq_pc  out  PC_W  PC of head entry
deq_instr  out  INST_W  instruction of head entry
count  out  $clog2(DEPTH+1)  number of occupied entries
fetch_pc  out  PC_W  current fetch PC, for testbench tracing

Behaviour:
- Reset (asynchronous, any cycle, including mid-operation):
  - fetch_pc = RESET_PC; count = 0; in-flight flag = 0.
  - deq_valid = 0; deq_pc = 0; deq_instr = 0.
  - Any pending memory response is discarded.
  - After release, imem_req = 1 with imem_addr = RESET_PC on the first clock.
- Credit rule: imem_req = !redirect_valid && (count + inflight < DEPTH).
  - imem_req is combinational from registered state and redirect_valid.
  - This rule guarantees the buffer never overflows.
- Request issue:
  - imem_addr = fetch_pc.
  - On a cycle with imem_req = 1: inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 4.
  - The increment wraps modulo 2^PC_W; no error is flagged.
- Response: in the cycle after a request, if inflight = 1 and redirect_valid = 0, enqueue {inflight_pc, imem_rdata} at the tail.
  - inflight clears unless a new request issues that cycle.
- Throughput: one instruction per cycle in steady state when deq_ready stays high. Latency from request to deq_valid is 2 cycles: one cycle memory, one cycle buffer register.
- Dequeue:
  - deq_valid = (count != 0); deq_pc and deq_instr show the head entry.
  - Handshake on deq_valid && deq_ready; the head pointer advances.
  - When empty, deq_pc and deq_instr hold their last values; verification must not check them while deq_valid = 0.
- Simultaneous enqueue and dequeue: count unchanged; allowed at any occupancy, including full (DEPTH-1 held plus one in flight).
- Redirect (redirect_valid = 1 on a clock edge):
  - fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00}.
  - Buffer flushed: count <= 0 and pointers reset.
  - inflight <= 0; the response arriving in the redirect cycle is dropped.
  - imem_req = 0 in the redirect cycle; the first request to the new PC is made the next cycle.
  - A head handshake in the same cycle still completes, so decode owns that instruction; all other entries are dropped.
  - Back-to-back redirects: the last one wins; no request issues until redirect_valid is low.
- Pointers: head and tail are $clog2(DEPTH) bits and wrap naturally. Full and empty are derived from count, not from pointer equality.

Decomposition:
- Package riscv_fetch_pkg:
  - fetch_entry_t packed struct {pc, instr}, parameterised via localparams.
  - PC_STEP = 4.
  - Helper function align_pc() that clears bits [1:0].
- Sub-module fetch_fifo:
  - Circular buffer of fetch_entry_t with push, pop, synchronous flush and count.
  - Instantiated once.
  - The top level holds the PC register, in-flight tracking and credit logic.

Test Plan:
- Reset, then deq_ready = 1, with memory returning instr = addr ^ 32'hA5A5_0000 → imem_addr sequence 0, 4, 8, …; first deq_valid at cycle 2 with deq_pc = 0; one instruction per cycle thereafter.
- deq_ready = 0 with DEPTH = 4 → count saturates at 4; imem_req goes low after the 4th request; raising deq_ready drains PCs 0, 4, 8, 12 in order with no loss or duplicate.
- Buffer holds PCs 0x10–0x1C; pulse redirect_valid with redirect_pc = 0x43 → next cycle count = 0 and imem_addr = 0x40; the stale in-flight response does not appear; next deq_pc = 0x40.
- Redirect in the same cycle as a head handshake → head entry consumed once; first post-flush deq_pc = redirect target.
- fetch_pc = 0x1FC with PC_W = 9 → next request address 0x000 (wrap).
- Assert reset while full and mid-request → deq_valid = 0 and count = 0 immediately (asynchronous); after release, fetch restarts at RESET_PC.
